dmr_bus_checker: RTL

- Sits between the two redundant cores and the shared single-port data RAM in the dual-core fault-tolerant SoC.
- Consumes each core's data-bus stream (we/addr/data) and absorbs bounded skew between the two cores.
- Compares the two streams transaction by transaction and forwards only matching transactions to memory.
- Raises a sticky error flag on divergence, and a done flag with the result word when software writes the completion flag address.

---
 rtl/dmr_pkg.sv | 27 ++
 rtl/dmr_skew_fifo.sv | 46 ++++
 rtl/dmr_bus_checker.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dmr_pkg.sv
// Shared types and constants for the dual-core lockstep bus checker.
package dmr_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  localparam logic [31:0] FLAG_ADDR_DEF   = 32'h0000_1000;
  localparam logic [31:0] RESULT_ADDR_DEF = 32'h0000_1004;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [BUS_AW-1:0] addr;
    logic [BUS_DW-1:0] wdata;
  } bus_txn_t;

  // Read data returns outside this block, so wdata only matters on writes.
  function automatic logic txn_match(input bus_txn_t a, input bus_txn_t b);
    return (a.we == b.we) && (a.addr == b.addr) && (!a.we || (a.wdata == b.wdata));
  endfunction

endpackage

// File: rtl/dmr_skew_fifo.sv
// Per-core skew buffer: small synchronous FIFO of bus transactions, head is read combinationally.
module dmr_skew_fifo
  import dmr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  bus_txn_t din,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output bus_txn_t head
);

  localparam int PW = $clog2(DEPTH);

  bus_txn_t         mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/dmr_bus_checker.sv
// Lockstep checker: buffers both cores' bus streams, forwards matching pairs to RAM,
// halts on divergence or excessive skew, and latches completion/result writes.
//
//   state | meaning
//   RUN   | accepting requests, comparing heads, committing matched pairs
//   HALT  | divergence or skew timeout seen; no grants, no RAM requests until reset
//   DONE  | completion flag committed; no further grants until reset
module dmr_bus_checker
  import dmr_pkg::*;
#(
  // AW/DW must not exceed the packed transaction widths in dmr_pkg.
  parameter int             AW          = BUS_AW,
  parameter int             DW          = BUS_DW,
  parameter int             DEPTH       = 4,
  parameter int             MAX_SKEW    = 8,
  parameter logic [AW-1:0]  FLAG_ADDR   = AW'(FLAG_ADDR_DEF),
  parameter logic [AW-1:0]  RESULT_ADDR = AW'(RESULT_ADDR_DEF)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          enable_i,
  input  logic          c0_req_i,
  input  logic          c0_we_i,
  input  logic [AW-1:0] c0_addr_i,
  input  logic [DW-1:0] c0_wdata_i,
  output logic          c0_gnt_o,
  input  logic          c1_req_i,
  input  logic          c1_we_i,
  input  logic [AW-1:0] c1_addr_i,
  input  logic [DW-1:0] c1_wdata_i,
  output logic          c1_gnt_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_gnt_i,
  output logic          error_o,
  output logic          done_o,
  output logic [DW-1:0] result_o,
  output logic [7:0]    mismatch_cnt_o
);

  localparam int TW = $clog2(MAX_SKEW + 1);

  state_t   state;
  bus_txn_t in0, in1, head0, head1;
  logic     full0, full1, empty0, empty1;
  logic     both_valid, skewed, commit, issue, mismatch, timeout;
  logic [TW-1:0] skew_cnt;

  always_comb begin
    in0       = '0;
    in0.we    = c0_we_i;
    in0.addr  = BUS_AW'(c0_addr_i);
    in0.wdata = BUS_DW'(c0_wdata_i);
    in1       = '0;
    in1.we    = c1_we_i;
    in1.addr  = BUS_AW'(c1_addr_i);
    in1.wdata = BUS_DW'(c1_wdata_i);
  end

  assign c0_gnt_o = c0_req_i & enable_i & ~full0 & (state == RUN) & ~rst_i;
  assign c1_gnt_o = c1_req_i & enable_i & ~full1 & (state == RUN) & ~rst_i;

  // The issued pair stays at both heads until the RAM grants it.
  assign commit     = mem_req_o & mem_gnt_i;
  assign both_valid = !empty0 && !empty1;
  assign skewed     = empty0 ^ empty1;
  assign issue      = (state == RUN) && !mem_req_o && both_valid && txn_match(head0, head1);
  assign mismatch   = (state == RUN) && !mem_req_o && both_valid && !txn_match(head0, head1);
  assign timeout    = (state == RUN) && skewed && (skew_cnt == TW'(MAX_SKEW - 1));

  dmr_skew_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (c0_gnt_o),
    .din   (in0),
    .pop   (commit),
    .full  (full0),
    .empty (empty0),
    .head  (head0)
  );

  dmr_skew_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (c1_gnt_o),
    .din   (in1),
    .pop   (commit),
    .full  (full1),
    .empty (empty1),
    .head  (head1)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= RUN;
      skew_cnt       <= '0;
      mem_req_o      <= 1'b0;
      mem_we_o       <= 1'b0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
      error_o        <= 1'b0;
      done_o         <= 1'b0;
      result_o       <= '0;
      mismatch_cnt_o <= '0;
    end else begin
      if (!skewed)
        skew_cnt <= '0;
      else if (skew_cnt != TW'(MAX_SKEW))
        skew_cnt <= skew_cnt + TW'(1);

      // Mismatch and timeout are mutually exclusive, but either counts once.
      if (mismatch || timeout) begin
        error_o   <= 1'b1;
        state     <= HALT;
        mem_req_o <= 1'b0;
        if (mismatch_cnt_o != 8'hFF) mismatch_cnt_o <= mismatch_cnt_o + 8'd1;
      end else if (issue) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= head0.we;
        mem_addr_o  <= head0.addr[AW-1:0];
        mem_wdata_o <= head0.wdata[DW-1:0];
      end else if (commit) begin
        mem_req_o <= 1'b0;
        if (mem_we_o && (mem_addr_o == RESULT_ADDR))
          result_o <= mem_wdata_o;
        if (mem_we_o && (mem_addr_o == FLAG_ADDR) && (mem_wdata_o != '0)) begin
          done_o <= 1'b1;
          state  <= DONE;
        end
      end
    end
  end

endmodule
